// File: rtl/video_pkg.sv
// Shared constants and FSM encoding for the 40x30 character video RAM arbiter.
package video_pkg;

  localparam int unsigned VRAM_COLS  = 40;
  localparam int unsigned VRAM_ROWS  = 30;
  localparam int unsigned VRAM_DEPTH = (VRAM_COLS * VRAM_ROWS) / 4;
  localparam int unsigned VRAM_AW    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VGA_ISSUE,
    ST_VGA_RESP,
    ST_CPU_ISSUE,
    ST_CPU_RESP
  } state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: VGA scanout has fixed priority over a CPU port.
// Each access takes IDLE -> ISSUE -> RESP; out-of-range addresses never reach the RAM.
module vram_arbiter
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = VRAM_DEPTH,
  parameter int unsigned AW    = VRAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   vga_addr,
  output logic [31:0]   vga_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [3:0]    cpu_wmask,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   stall_cnt
);

  state_t        r_state, w_next;
  logic [31:0]   r_last_addr;
  logic          r_vga_pend;
  logic          r_vga_disc;
  logic [AW-1:0] r_vga_lat;
  logic [31:0]   r_vga_data;
  logic          r_cpu_we;
  logic [AW-1:0] r_cpu_addr;
  logic [31:0]   r_cpu_wdata;
  logic [3:0]    r_cpu_wmask;
  logic          r_cpu_ready;
  logic [31:0]   r_cpu_rdata;
  logic [15:0]   r_stall_cnt;

  logic w_mismatch, w_vga_in, w_vga_new, w_cpu_in;
  logic w_vga_go, w_cpu_go, w_stall;

  assign w_mismatch = (vga_addr != r_last_addr);
  assign w_vga_in   = (vga_addr < DEPTH);
  assign w_vga_new  = w_mismatch && w_vga_in;
  assign w_cpu_in   = (32'(r_cpu_addr) < DEPTH);

  // A fresh mismatch overrides a stale pending fetch, so a pending address is
  // only served when no newer address is arriving this cycle.
  assign w_vga_go = (r_state == ST_IDLE) &&
                    ((r_vga_pend && !w_mismatch) || w_vga_new);
  // The cycle cpu_ready is high the CPU still holds cpu_req; don't regrant it.
  assign w_cpu_go = (r_state == ST_IDLE) && !w_vga_go && cpu_req && !r_cpu_ready;
  assign w_stall  = cpu_req && !r_cpu_ready &&
                    ((r_state == ST_VGA_ISSUE) || (r_state == ST_VGA_RESP) ||
                     ((r_state == ST_IDLE) && w_vga_go));

  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_vga_go)      w_next = ST_VGA_ISSUE;
        else if (w_cpu_go) w_next = ST_CPU_ISSUE;
      end
      ST_VGA_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = r_vga_lat;
        w_next   = ST_VGA_RESP;
      end
      ST_VGA_RESP: w_next = ST_IDLE;
      ST_CPU_ISSUE: begin
        if (w_cpu_in) begin
          mem_en    = 1'b1;
          mem_addr  = r_cpu_addr;
          mem_wdata = r_cpu_wdata;
          mem_we    = r_cpu_we ? r_cpu_wmask : 4'b0000;
        end
        w_next = ST_CPU_RESP;
      end
      ST_CPU_RESP: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_addr <= '1;
      r_vga_pend  <= 1'b0;
      r_vga_disc  <= 1'b0;
      r_vga_lat   <= '0;
      r_vga_data  <= '0;
      r_cpu_we    <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
      r_cpu_wmask <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_cpu_ready <= 1'b0;

      if (w_mismatch) begin
        r_last_addr <= vga_addr;
        r_vga_pend  <= w_vga_in;
        if (w_vga_in) r_vga_lat  <= vga_addr[AW-1:0];
        else          r_vga_data <= '0;
      end else if ((r_state == ST_VGA_RESP) && !r_vga_disc) begin
        r_vga_data <= mem_rdata;
        r_vga_pend <= 1'b0;
      end

      // An address change while a fetch is in flight makes that fetch stale.
      if ((r_state == ST_VGA_ISSUE) && w_mismatch) r_vga_disc <= 1'b1;
      else if (r_state == ST_VGA_RESP)             r_vga_disc <= 1'b0;

      if (w_cpu_go) begin
        r_cpu_we    <= cpu_we;
        r_cpu_addr  <= cpu_addr;
        r_cpu_wdata <= cpu_wdata;
        r_cpu_wmask <= cpu_wmask;
      end

      if (r_state == ST_CPU_RESP) begin
        r_cpu_ready <= 1'b1;
        r_cpu_rdata <= (!r_cpu_we && w_cpu_in) ? mem_rdata : '0;
      end

      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign vga_data  = r_vga_data;
  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign stall_cnt = r_stall_cnt;

endmodule
